// File: rtl/dcache_refill_engine.sv
// Read/write-miss refill engine: fetches one cache block from the next level as
// BEATS serial beats and delivers it to the cache in a single strobe cycle.
module dcache_refill_engine #(
   parameter int BLOCK_BITS  = 1024,
   parameter int BEAT_W      = 128,
   parameter int OFFSET_BITS = 7,
   parameter int CNT_W       = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    read_repair_request,
   input  logic                    write_miss_repair,
   input  logic [31:0]             missed_addr,
   output logic                    repair_resolved,
   output logic                    sent_repair,
   output logic [31:0]             waddr,
   output logic [BLOCK_BITS-1:0]   wdata,
   output logic [BLOCK_BITS/8-1:0] wmask,
   output logic                    busy,
   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic [31:0]             mem_req_addr,
   input  logic                    mem_resp_valid,
   input  logic [BEAT_W-1:0]       mem_resp_data,
   output logic [CNT_W-1:0]        read_miss_cnt,
   output logic [CNT_W-1:0]        write_miss_cnt
);

   localparam int BEATS = BLOCK_BITS / BEAT_W;
   localparam int CW    = $clog2(BEATS);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, REQ, FILL, DELIVER} state_t;

   state_t                       state_q, state_d;
   logic [CW-1:0]                beat_cnt_q;
   logic [31:0]                  addr_q;
   logic [BLOCK_BITS-BEAT_W-1:0] fill_q;
   logic                         req_any;
   logic                         last_beat;

   assign req_any   = read_repair_request | write_miss_repair;
   assign last_beat = mem_resp_valid && (beat_cnt_q == LAST_BEAT);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: state_d gets its default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_any)       state_d = REQ;
         REQ:     if (mem_req_ready) state_d = FILL;
         FILL:    if (last_beat)     state_d = DELIVER;
         DELIVER:                    state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q         <= '0;
         beat_cnt_q     <= '0;
         waddr          <= '0;
         wdata          <= '0;
         read_miss_cnt  <= '0;
         write_miss_cnt <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_any) begin
                  addr_q <= {missed_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                  // A simultaneous read and write pulse is a single write miss.
                  if (write_miss_repair) begin
                     if (write_miss_cnt != '1) write_miss_cnt <= write_miss_cnt + CNT_W'(1);
                  end else begin
                     if (read_miss_cnt != '1) read_miss_cnt <= read_miss_cnt + CNT_W'(1);
                  end
               end
            end
            REQ: begin
               if (mem_req_ready) beat_cnt_q <= '0;
            end
            FILL: begin
               if (mem_resp_valid) begin
                  if (beat_cnt_q == LAST_BEAT) begin
                     // The final beat goes straight into wdata; waddr/wdata then
                     // hold until the next delivery.
                     waddr      <= addr_q;
                     wdata      <= {mem_resp_data, fill_q};
                     beat_cnt_q <= '0;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + CW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the staging buffer has no reset; every fill rewrites all of it before
   // delivery, so stale beats from an aborted fill can never reach wdata.
   always_ff @(posedge clk) begin
      if (state_q == FILL && mem_resp_valid && beat_cnt_q != LAST_BEAT)
         fill_q[beat_cnt_q*BEAT_W +: BEAT_W] <= mem_resp_data;
   end

   assign repair_resolved = (state_q == DELIVER);
   assign sent_repair     = (state_q == DELIVER);
   assign wmask           = {(BLOCK_BITS/8){state_q == DELIVER}};
   assign busy            = (state_q != IDLE);
   assign mem_req_valid   = (state_q == REQ);
   assign mem_req_addr    = addr_q;

endmodule

// File: tb/tb_dcache_refill_engine.sv
// Scoreboard bench for dcache_refill_engine: expected blocks are queued at request
// time and compared when the delivery strobe appears.
module tb_dcache_refill_engine;

   localparam int BLOCK_BITS = 1024;
   localparam int BEAT_W     = 128;
   localparam int BEATS      = BLOCK_BITS / BEAT_W;
   localparam int SAT_W      = 4;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    read_repair_request = 1'b0;
   logic                    write_miss_repair = 1'b0;
   logic [31:0]             missed_addr = '0;
   logic                    mem_req_ready = 1'b0;
   logic                    mem_resp_valid = 1'b0;
   logic [BEAT_W-1:0]       mem_resp_data = '0;

   logic                    repair_resolved, sent_repair, busy, mem_req_valid;
   logic [31:0]             waddr, mem_req_addr;
   logic [BLOCK_BITS-1:0]   wdata;
   logic [BLOCK_BITS/8-1:0] wmask;
   logic [15:0]             read_miss_cnt, write_miss_cnt;

   logic                    s_rr, s_sr, s_busy, s_mrv;
   logic [31:0]             s_waddr, s_mra;
   logic [BLOCK_BITS-1:0]   s_wdata;
   logic [BLOCK_BITS/8-1:0] s_wmask;
   logic [SAT_W-1:0]        s_rd_cnt, s_wr_cnt;

   dcache_refill_engine dut (
      .clk(clk), .rst(rst),
      .read_repair_request(read_repair_request), .write_miss_repair(write_miss_repair),
      .missed_addr(missed_addr),
      .repair_resolved(repair_resolved), .sent_repair(sent_repair),
      .waddr(waddr), .wdata(wdata), .wmask(wmask), .busy(busy),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .read_miss_cnt(read_miss_cnt), .write_miss_cnt(write_miss_cnt)
   );

   // Narrow-counter copy on the same stimulus so saturation is reachable quickly.
   dcache_refill_engine #(.CNT_W(SAT_W)) dut_sat (
      .clk(clk), .rst(rst),
      .read_repair_request(read_repair_request), .write_miss_repair(write_miss_repair),
      .missed_addr(missed_addr),
      .repair_resolved(s_rr), .sent_repair(s_sr),
      .waddr(s_waddr), .wdata(s_wdata), .wmask(s_wmask), .busy(s_busy),
      .mem_req_valid(s_mrv), .mem_req_ready(mem_req_ready), .mem_req_addr(s_mra),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .read_miss_cnt(s_rd_cnt), .write_miss_cnt(s_wr_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]           addr;
      logic [BLOCK_BITS-1:0] data;
      int                    cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   m_rd = 0;
   int   m_wr = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int sat_of(input int n);
      return (n > (1 << SAT_W) - 1) ? (1 << SAT_W) - 1 : n;
   endfunction

   // Delivery monitor: samples mid-cycle and pops the scoreboard on each strobe.
   always @(posedge clk) begin
      #2;
      if (repair_resolved) begin
         if (sb.size() == 0) begin
            check("unexpected_strobe", repair_resolved, 0);
         end else begin
            mon_e = sb.pop_front();
            check("strobe_cycle", cyc, mon_e.cyc);
            check("sent_repair", sent_repair, 1);
            check("waddr", waddr, mon_e.addr);
            check("wmask", wmask, {128{1'b1}});
            for (int i = 0; i < BEATS; i++)
               check($sformatf("wdata_beat%0d", i), wdata[i*BEAT_W +: BEAT_W],
                     mon_e.data[i*BEAT_W +: BEAT_W]);
         end
      end
   end

   task automatic check_counts();
      check("read_miss_cnt", read_miss_cnt, m_rd);
      check("write_miss_cnt", write_miss_cnt, m_wr);
      check("sat_read_cnt", s_rd_cnt, sat_of(m_rd));
      check("sat_write_cnt", s_wr_cnt, sat_of(m_wr));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_resolved"}, repair_resolved, 0);
      check({tag, "_sent"}, sent_repair, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_req_valid"}, mem_req_valid, 0);
      check({tag, "_waddr"}, waddr, 0);
      check({tag, "_req_addr"}, mem_req_addr, 0);
      check({tag, "_wmask"}, wmask, 0);
      check({tag, "_wdata_or"}, |wdata, 0);
      check({tag, "_rd_cnt"}, read_miss_cnt, 0);
      check({tag, "_wr_cnt"}, write_miss_cnt, 0);
   endtask

   // One complete miss: request, optional ready stall, beats with an optional gap,
   // optional ignored request pulse during the fill.
   task automatic do_miss(input logic [31:0] a, input bit rd, input bit wr, input int rdly,
                          input int gap_beat, input int gap_len, input logic [31:0] base,
                          input bit inject);
      exp_t        e;
      logic [31:0] ea;
      logic [31:0] w;
      ea = {a[31:7], 7'b0};
      for (int b = 0; b < BEATS; b++) begin
         w = base + 32'(b);
         e.data[b*BEAT_W +: BEAT_W] = {4{w}};
      end
      e.addr = ea;

      @(posedge clk); #1;
      read_repair_request = rd;
      write_miss_repair   = wr;
      missed_addr         = a;
      mem_req_ready       = (rdly == 0);
      e.cyc = cyc + 1 + (BEATS + 1) + rdly + gap_len;
      sb.push_back(e);
      if (wr) m_wr++;
      else    m_rd++;

      @(posedge clk); #1;
      read_repair_request = 1'b0;
      write_miss_repair   = 1'b0;
      missed_addr         = 32'hDEAD_BEEF;
      check("req_valid", mem_req_valid, 1);
      check("req_addr", mem_req_addr, ea);
      check("busy_in_req", busy, 1);
      for (int i = 0; i < rdly; i++) begin
         @(posedge clk); #1;
         check("req_hold_valid", mem_req_valid, 1);
         check("req_hold_addr", mem_req_addr, ea);
      end
      mem_req_ready = 1'b1;

      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      for (int b = 0; b < BEATS; b++) begin
         if (b == gap_beat) begin
            mem_resp_valid = 1'b0;
            repeat (gap_len) begin @(posedge clk); #1; end
         end
         w = base + 32'(b);
         mem_resp_valid = 1'b1;
         mem_resp_data  = {4{w}};
         if (inject && b == 3) begin
            read_repair_request = 1'b1;
            missed_addr         = 32'h0000_9980;
         end
         @(posedge clk); #1;
         read_repair_request = 1'b0;
      end
      mem_resp_valid = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("sb_drained", sb.size(), 0);
      check("idle_after", busy, 0);
      check("wmask_idle", wmask, 0);
      check("req_addr_kept", mem_req_addr, ea);
      check_counts();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // Basic read miss, back-to-back, ready already high.
      do_miss(32'h0000_1234, 1'b1, 1'b0, 0, -1, 0, 32'hA000_0000, 1'b0);
      // Write miss with 5-cycle ready stall and 3-cycle beat gap.
      do_miss(32'h0004_56FF, 1'b0, 1'b1, 5, 4, 3, 32'hB100_0000, 1'b0);
      // Simultaneous read and write pulses count as one write miss.
      do_miss(32'h0000_2080, 1'b1, 1'b1, 0, -1, 0, 32'hC200_0000, 1'b0);
      // Request pulse during FILL is ignored.
      do_miss(32'h0001_0000, 1'b0, 1'b1, 1, 2, 1, 32'hD300_0000, 1'b1);

      // Stray response beats while idle are ignored.
      @(posedge clk); #1;
      mem_resp_valid = 1'b1;
      mem_resp_data  = {4{32'hEEEE_EEEE}};
      repeat (3) @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      check("stray_busy", busy, 0);
      check_counts();
      do_miss(32'h0000_3300, 1'b1, 1'b0, 0, -1, 0, 32'h1100_0000, 1'b0);

      // Reset after 4 of 8 beats aborts the fill with no strobe.
      @(posedge clk); #1;
      read_repair_request = 1'b1;
      missed_addr         = 32'h0000_7700;
      mem_req_ready       = 1'b1;
      @(posedge clk); #1;
      read_repair_request = 1'b0;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = {4{32'h5A5A_0000 + 32'(b)}};
         @(posedge clk); #1;
      end
      check("busy_mid_fill", busy, 1);
      rst            = 1'b1;
      mem_resp_valid = 1'b0;
      #1;
      check_reset_outputs("abort");
      m_rd = 0;
      m_wr = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("no_strobe_after_abort", repair_resolved, 0);
      do_miss(32'h0000_7700, 1'b1, 1'b0, 0, -1, 0, 32'h6600_0000, 1'b0);

      // Drive the narrow counters into saturation.
      for (int n = 0; n < (1 << SAT_W) + 1; n++)
         do_miss(32'h0010_0000 + 32'(n * 128), 1'b1, 1'b0, 0, -1, 0, 32'h7000_0000 + 32'(n << 8), 1'b0);
      check("sat_read_final", s_rd_cnt, {SAT_W{1'b1}});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
